// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies.
package mdu_ctrl_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  typedef enum logic {
    IDLE,
    BUSY
  } md_state_e;

  // Ops that occupy the unit for multiple cycles and so must stall dependents.
  function automatic logic md_is_long(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: computes results at issue, then models the
// iterative latency with a down-counter before committing to HI/LO.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use_D,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        stall_md
);

  md_state_e   state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_pend_q, lo_pend_q;
  logic        pend_wr_q;

  logic               accept;
  logic               b_zero;
  logic [31:0]        b_safe;
  logic signed [63:0] a_ext, b_ext, prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0]        quo_u, rem_u;

  assign accept = start & ~req & (state_q == IDLE);

  always_comb begin
    b_zero = (B == 32'd0);
    // Divide by a harmless 1 on B=0; the commit is suppressed anyway.
    b_safe = b_zero ? 32'd1 : B;
    a_ext  = {{32{A[31]}}, A};
    b_ext  = {{32{B[31]}}, B};
    prod_s = a_ext * b_ext;
    prod_u = {32'd0, A} * {32'd0, B};
    quo_s  = $signed(A) / $signed(b_safe);
    rem_s  = $signed(A) % $signed(b_safe);
    quo_u  = A / b_safe;
    rem_u  = A % b_safe;
  end

  assign stall_md = md_use_D & (busy | (start & md_is_long(op) & ~req));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      hi_pend_q <= 32'd0;
      lo_pend_q <= 32'd0;
      pend_wr_q <= 1'b0;
      busy      <= 1'b0;
      HI        <= 32'd0;
      LO        <= 32'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            case (op)
              MD_MULT: begin
                hi_pend_q <= prod_s[63:32];
                lo_pend_q <= prod_s[31:0];
                pend_wr_q <= 1'b1;
                cnt_q     <= 4'(MULT_CYCLES);
                busy      <= 1'b1;
                state_q   <= BUSY;
              end
              MD_MULTU: begin
                hi_pend_q <= prod_u[63:32];
                lo_pend_q <= prod_u[31:0];
                pend_wr_q <= 1'b1;
                cnt_q     <= 4'(MULT_CYCLES);
                busy      <= 1'b1;
                state_q   <= BUSY;
              end
              MD_DIV: begin
                hi_pend_q <= rem_s;
                lo_pend_q <= quo_s;
                pend_wr_q <= ~b_zero;
                cnt_q     <= 4'(DIV_CYCLES);
                busy      <= 1'b1;
                state_q   <= BUSY;
              end
              MD_DIVU: begin
                hi_pend_q <= rem_u;
                lo_pend_q <= quo_u;
                pend_wr_q <= ~b_zero;
                cnt_q     <= 4'(DIV_CYCLES);
                busy      <= 1'b1;
                state_q   <= BUSY;
              end
              MD_MTHI: HI <= A;
              MD_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        BUSY: begin
          // req is deliberately ignored here: an in-flight op always commits.
          if (cnt_q == 4'd1) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            busy    <= 1'b0;
            if (pend_wr_q) begin
              HI <= hi_pend_q;
              LO <= lo_pend_q;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: expected HI/LO/latency pushed to a
// scoreboard at issue and popped when busy falls.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, req, start, md_use_D;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic [31:0] HI, LO;
  logic        busy, stall_md;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_hi, m_lo;

  mdu_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .md_use_D(md_use_D),
    .HI      (HI),
    .LO      (LO),
    .busy    (busy),
    .stall_md(stall_md)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi, input logic [31:0] lo);
    exp_t        e;
    longint      p;
    logic [63:0] pu;
    int          sa, sb;
    e.hi = hi; e.lo = lo; e.cycles = 0;
    sa = a; sb = b;
    case (o)
      MD_MULT: begin
        p = longint'(sa) * longint'(sb);
        e.hi = p[63:32]; e.lo = p[31:0]; e.cycles = 5;
      end
      MD_MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        e.hi = pu[63:32]; e.lo = pu[31:0]; e.cycles = 5;
      end
      MD_DIV: begin
        if (b != 0) begin e.lo = sa / sb; e.hi = sa % sb; end
        e.cycles = 10;
      end
      MD_DIVU: begin
        if (b != 0) begin e.lo = a / b; e.hi = a % b; end
        e.cycles = 10;
      end
      MD_MTHI: e.hi = a;
      MD_MTLO: e.lo = a;
      default: ;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic r);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b; req = r;
    @(posedge clk);
    #1;
    start = 1'b0; req = 1'b0; op = 3'd6;
  endtask

  task automatic wait_busy(output int n, output bit timed_out);
    n = 0; timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin timed_out = 1'b0; break; end
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 1'b0; start = 1'b0; op = 3'd6; A = '0; B = '0; md_use_D = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", HI); end
    n_checks++; if (LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", LO); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (stall_md !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_md); end
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_spec_ops;
    exp_t e;
    int   n;
    bit   to;
    logic [2:0]  ops[3] = '{MD_MULT, MD_DIVU, MD_DIV};
    logic [31:0] as[3] = '{32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9};
    logic [31:0] bs[3] = '{32'd7, 32'd7, 32'd2};
    exp_t        ex[3];
    ex[0] = '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, cycles: 5};
    ex[1] = '{hi: 32'd2, lo: 32'd14, cycles: 10};
    ex[2] = '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, cycles: 10};
    for (int k = 0; k < 3; k++) begin
      issue(ops[k], as[k], bs[k], 1'b0);
      sb_q.push_back(ex[k]);
      wait_busy(n, to);
      e = sb_q.pop_front();
      n_checks++; if (to || n != e.cycles) begin n_fail++;
        $display("FAIL spec%0d_cycles: got %0d (timeout %0d) expected %0d", k, n, to, e.cycles); end
      n_checks++; if (HI !== e.hi) begin n_fail++; $display("FAIL spec%0d_hi: got %h expected %h", k, HI, e.hi); end
      n_checks++; if (LO !== e.lo) begin n_fail++; $display("FAIL spec%0d_lo: got %h expected %h", k, LO, e.lo); end
      m_hi = e.hi; m_lo = e.lo;
    end
  endtask

  task automatic test_random;
    exp_t        e;
    int          n;
    bit          to;
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int k = 0; k < 6; k++) begin
      o = 3'(k % 4);
      a = $urandom;
      b = (o >= MD_DIV) ? (($urandom_range(0, 1) == 1) ? -32'($urandom_range(1, 5000))
                                                       : 32'($urandom_range(1, 5000)))
                        : $urandom;
      issue(o, a, b, 1'b0);
      sb_q.push_back(model(o, a, b, m_hi, m_lo));
      wait_busy(n, to);
      e = sb_q.pop_front();
      n_checks++; if (to || n != e.cycles) begin n_fail++;
        $display("FAIL rand%0d_cycles: got %0d expected %0d", k, n, e.cycles); end
      n_checks++; if (HI !== e.hi) begin n_fail++;
        $display("FAIL rand%0d_hi: op %0d a %h b %h got %h expected %h", k, o, a, b, HI, e.hi); end
      n_checks++; if (LO !== e.lo) begin n_fail++;
        $display("FAIL rand%0d_lo: op %0d a %h b %h got %h expected %h", k, o, a, b, LO, e.lo); end
      m_hi = e.hi; m_lo = e.lo;
    end
  endtask

  task automatic test_stall;
    exp_t e;
    int   n = 0;
    bit   to = 1'b1;
    md_use_D = 1'b1;
    @(negedge clk);
    start = 1'b1; op = MD_MULT; A = 32'd2; B = 32'd3; req = 1'b0;
    #1;
    n_checks++; if (stall_md !== 1'b1) begin n_fail++; $display("FAIL stall_issue: got %b expected 1", stall_md); end
    sb_q.push_back(model(MD_MULT, 32'd2, 32'd3, m_hi, m_lo));
    @(posedge clk);
    #1 start = 1'b0; op = 3'd6;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin to = 1'b0; break; end
      n++;
      n_checks++; if (stall_md !== 1'b1) begin n_fail++;
        $display("FAIL stall_busy%0d: got %b expected 1", n, stall_md); end
    end
    e = sb_q.pop_front();
    n_checks++; if (stall_md !== 1'b0) begin n_fail++; $display("FAIL stall_after: got %b expected 0", stall_md); end
    n_checks++; if (to || n != e.cycles) begin n_fail++;
      $display("FAIL stall_cycles: got %0d expected %0d", n, e.cycles); end
    n_checks++; if (LO !== e.lo) begin n_fail++; $display("FAIL stall_lo: got %h expected %h", LO, e.lo); end
    m_hi = e.hi; m_lo = e.lo;
    md_use_D = 1'b0;
  endtask

  task automatic test_req;
    exp_t e;
    int   n = 0;
    bit   to = 1'b1;
    issue(MD_MULT, 32'd9, 32'd9, 1'b1);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
    n_checks++; if (HI !== m_hi || LO !== m_lo) begin n_fail++;
      $display("FAIL flush_hilo: got %h/%h expected %h/%h", HI, LO, m_hi, m_lo); end
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    e = '{hi: 32'd1, lo: 32'hFFFF_FFFE, cycles: 5};
    sb_q.push_back(e);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin to = 1'b0; break; end
      n++;
      req = (n == 2 || n == 3);
    end
    req = 1'b0;
    e = sb_q.pop_front();
    n_checks++; if (to || n != e.cycles) begin n_fail++;
      $display("FAIL req_busy_cycles: got %0d expected %0d", n, e.cycles); end
    n_checks++; if (HI !== e.hi || LO !== e.lo) begin n_fail++;
      $display("FAIL req_busy_commit: got %h/%h expected %h/%h", HI, LO, e.hi, e.lo); end
    m_hi = e.hi; m_lo = e.lo;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   n;
    bit   to;
    issue(MD_MULT, 32'd1000, 32'd1000, 1'b0);
    sb_q.push_back(model(MD_MULT, 32'd1000, 32'd1000, m_hi, m_lo));
    start = 1'b1; op = MD_MTHI; A = 32'hDEAD_BEEF;
    wait_busy(n, to);
    start = 1'b0; op = 3'd6;
    e = sb_q.pop_front();
    n_checks++; if (to || n != e.cycles) begin n_fail++;
      $display("FAIL b2b_cycles: got %0d expected %0d", n, e.cycles); end
    n_checks++; if (HI !== e.hi || LO !== e.lo) begin n_fail++;
      $display("FAIL b2b_ignored_start: got %h/%h expected %h/%h", HI, LO, e.hi, e.lo); end
    m_hi = e.hi; m_lo = e.lo;
  endtask

  task automatic test_div_zero_mtx;
    exp_t e;
    int   n;
    bit   to;
    issue(MD_DIV, 32'd123, 32'd0, 1'b0);
    sb_q.push_back(model(MD_DIV, 32'd123, 32'd0, m_hi, m_lo));
    wait_busy(n, to);
    e = sb_q.pop_front();
    n_checks++; if (to || n != 10) begin n_fail++; $display("FAIL divzero_cycles: got %0d expected 10", n); end
    n_checks++; if (HI !== m_hi || LO !== m_lo) begin n_fail++;
      $display("FAIL divzero_hilo: got %h/%h expected %h/%h", HI, LO, e.hi, e.lo); end
    issue(MD_MTHI, 32'd5, 32'd0, 1'b0);
    @(negedge clk);
    n_checks++; if (HI !== 32'd5) begin n_fail++; $display("FAIL mthi_hi: got %h expected 5", HI); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b expected 0", busy); end
    m_hi = 32'd5;
    issue(MD_MTLO, 32'hA5A5_5A5A, 32'd0, 1'b0);
    @(negedge clk);
    n_checks++; if (LO !== 32'hA5A5_5A5A || HI !== 32'd5) begin n_fail++;
      $display("FAIL mtlo: got %h/%h expected 00000005/a5a55a5a", HI, LO); end
    m_lo = 32'hA5A5_5A5A;
    issue(3'd6, 32'd77, 32'd1, 1'b0);
    issue(3'd7, 32'd77, 32'd1, 1'b0);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin n_fail++;
      $display("FAIL nop_ops: got busy %b %h/%h expected 0 %h/%h", busy, HI, LO, m_hi, m_lo); end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    bit seen_busy = 1'b0;
    issue(MD_DIV, 32'd1000, 32'd3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) n++;
      if (n == 3) break;
    end
    n_checks++; if (n != 3) begin n_fail++; $display("FAIL rstmid_reach: got %0d busy cycles expected 3", n); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_checks++; if (HI !== 32'd0 || LO !== 32'd0) begin n_fail++;
      $display("FAIL rstmid_hilo: got %h/%h expected 0/0", HI, LO); end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    n_checks++; if (seen_busy || HI !== 32'd0 || LO !== 32'd0) begin n_fail++;
      $display("FAIL rstmid_no_commit: got busy_seen %b %h/%h expected 0 0/0", seen_busy, HI, LO); end
  endtask

  initial begin
    test_reset();
    test_spec_ops();
    test_random();
    test_stall();
    test_req();
    test_back_to_back();
    test_div_zero_mtx();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
